// File: rtl/alu_shift_unit_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: default width,
// ALU_FUN shift-mode encodings and FSM state encodings.
package alu_shift_unit_pkg;

   localparam int OPERAND_WIDTH_DEF = 8;

   // ALU_FUN encodings; 3'b101..3'b111 are reserved and hold the word
   typedef enum logic [2:0] {
      FUN_LSR = 3'b000,
      FUN_LSL = 3'b001,
      FUN_ASR = 3'b010,
      FUN_ROR = 3'b011,
      FUN_ROL = 3'b100
   } shift_fun_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/alu_shift_unit_if.sv
// Operand/control/result bundle of the shift unit. The master side (ALU
// decode) drives operands and the start request; the slave side (the unit)
// returns status and the result.
interface alu_shift_unit_if
   import alu_shift_unit_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
   parameter int SHAMT_WIDTH   = $clog2(OPERAND_WIDTH)
);
   logic [OPERAND_WIDTH-1:0] A;
   logic [OPERAND_WIDTH-1:0] B;
   logic                     OP_SEL;
   logic [2:0]               ALU_FUN;
   logic [SHAMT_WIDTH-1:0]   SHAMT;
   logic                     Shift_Enable;
   logic                     Busy;
   logic                     SHIFT_Flag;
   logic [OPERAND_WIDTH-1:0] SHIFT_OUT;
   logic                     Carry_Out;

   modport master (
      output A, B, OP_SEL, ALU_FUN, SHAMT, Shift_Enable,
      input  Busy, SHIFT_Flag, SHIFT_OUT, Carry_Out
   );

   modport slave (
      input  A, B, OP_SEL, ALU_FUN, SHAMT, Shift_Enable,
      output Busy, SHIFT_Flag, SHIFT_OUT, Carry_Out
   );
endinterface

// File: rtl/alu_shift_unit_shift_step.sv
// One single-bit shift/rotate step. Purely combinational: returns the
// stepped word and the bit that left it. Reserved modes hold the word and
// report a zero carry.
module shift_step
   import alu_shift_unit_pkg::*;
#(
   parameter int WIDTH = OPERAND_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] word_i,
   input  logic [2:0]       fun_i,
   output logic [WIDTH-1:0] word_o,
   output logic             bit_o
);

   // Select the one-step transform for the requested mode
   always_comb begin
      word_o = word_i;
      bit_o  = 1'b0;
      case (shift_fun_e'(fun_i))
         FUN_LSR: begin
            word_o = {1'b0, word_i[WIDTH-1:1]};
            bit_o  = word_i[0];
         end
         FUN_LSL: begin
            word_o = {word_i[WIDTH-2:0], 1'b0};
            bit_o  = word_i[WIDTH-1];
         end
         FUN_ASR: begin
            word_o = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
            bit_o  = word_i[0];
         end
         FUN_ROR: begin
            word_o = {word_i[0], word_i[WIDTH-1:1]};
            bit_o  = word_i[0];
         end
         FUN_ROL: begin
            word_o = {word_i[WIDTH-2:0], word_i[WIDTH-1]};
            bit_o  = word_i[WIDTH-1];
         end
         default: begin
            word_o = word_i;
            bit_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_shift_unit.sv
// Multi-cycle shift/rotate unit. A start in IDLE captures the selected
// operand, mode and count; the unit then applies one step per clock and,
// once the count reaches zero, publishes the result and last shifted-out
// bit together with a one-cycle completion flag.
module alu_shift_unit
   import alu_shift_unit_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
   parameter int SHAMT_WIDTH   = $clog2(OPERAND_WIDTH)
) (
   input  logic              CLK,
   input  logic              RST,
   alu_shift_unit_if.slave   bus
);

   state_e                   state_q, state_d;
   logic [OPERAND_WIDTH-1:0] work_q, work_d;
   logic [2:0]               fun_q, fun_d;
   logic [SHAMT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                     carry_q, carry_d;
   logic [OPERAND_WIDTH-1:0] shift_out_q, shift_out_d;
   logic                     carry_out_q, carry_out_d;
   logic                     flag_q, flag_d;

   logic [OPERAND_WIDTH-1:0] step_word;
   logic                     step_bit;

   shift_step #(
      .WIDTH (OPERAND_WIDTH)
   ) u_step (
      .word_i (work_q),
      .fun_i  (fun_q),
      .word_o (step_word),
      .bit_o  (step_bit)
   );

   // Next-state logic: capture on start, step while the count is non-zero,
   // publish and return to IDLE when it reaches zero
   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      fun_d       = fun_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      shift_out_d = shift_out_q;
      carry_out_d = carry_out_q;
      flag_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.Shift_Enable) begin
               work_d  = bus.OP_SEL ? bus.B : bus.A;
               fun_d   = bus.ALU_FUN;
               cnt_d   = bus.SHAMT;
               carry_d = 1'b0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               work_d  = step_word;
               carry_d = step_bit;
               cnt_d   = cnt_q - SHAMT_WIDTH'(1);
            end else begin
               shift_out_d = work_q;
               carry_out_d = carry_q;
               flag_d      = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and output registers; reset drops any operation in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         fun_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         shift_out_q <= '0;
         carry_out_q <= 1'b0;
         flag_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         fun_q       <= fun_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         shift_out_q <= shift_out_d;
         carry_out_q <= carry_out_d;
         flag_q      <= flag_d;
      end
   end

   assign bus.Busy       = (state_q == ST_SHIFT);
   assign bus.SHIFT_Flag = flag_q;
   assign bus.SHIFT_OUT  = shift_out_q;
   assign bus.Carry_Out  = carry_out_q;

endmodule
